// File: rtl/vec_sub_pipe.sv
// Lane-wise vector subtractor: a[i] = y[i] - b[i] mod 2^W, per-lane borrow.
// Two registered stages with valid/ready on both sides and a transfer counter.
module vec_sub_pipe #(
  parameter int W     = 8,
  parameter int N     = 4,
  parameter int CNT_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0][W-1:0] y,
  input  logic [N-1:0][W-1:0] b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [N-1:0][W-1:0] a,
  output logic [N-1:0]        borrow,
  output logic [CNT_W-1:0]    out_count
);

  logic                s1_valid;
  logic [N-1:0][W-1:0] y_r;
  logic [N-1:0][W-1:0] b_r;

  logic                s2_valid;
  logic [N-1:0][W-1:0] a_r;
  logic [N-1:0]        borrow_r;

  logic [CNT_W-1:0]    cnt;

  logic                s1_adv;
  logic                s2_adv;
  logic                out_fire;

  logic [N-1:0][W-1:0] diff;
  logic [N-1:0]        diff_bw;

  // A full stage may still advance if the stage after it is draining.
  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign out_fire = s2_valid && out_ready;

  // Borrow is the carry-out of a one-bit-wider subtraction.
  always_comb begin
    diff    = '0;
    diff_bw = '0;
    for (int i = 0; i < N; i++) begin
      {diff_bw[i], diff[i]} =
        {1'b0, y_r[i]} - {1'b0, b_r[i]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      y_r      <= '0;
      b_r      <= '0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      y_r      <= y;
      b_r      <= b;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s2_valid <= 1'b0;
      a_r      <= '0;
      borrow_r <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      a_r      <= diff;
      borrow_r <= diff_bw;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (out_fire) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign a         = a_r;
  assign borrow    = borrow_r;
  assign out_count = cnt;

endmodule

// File: tb/tb_vec_sub_pipe.sv
// Bench for vec_sub_pipe: scoreboard of y-b results against observed
// output transfers, plus a CNT_W=4 copy for counter wrap.
module tb_vec_sub_pipe;

  localparam int W = 8;
  localparam int N = 4;
  localparam int RW = N + N * W;

  logic                clock;
  logic                reset;
  logic                in_valid;
  logic                in_ready;
  logic [N-1:0][W-1:0] y;
  logic [N-1:0][W-1:0] b;
  logic                out_valid;
  logic                out_ready;
  logic [N-1:0][W-1:0] a;
  logic [N-1:0]        borrow;
  logic [15:0]         out_count;

  logic                in_ready4;
  logic                out_valid4;
  logic [N-1:0][W-1:0] a4;
  logic [N-1:0]        borrow4;
  logic [3:0]          out_count4;

  int n_cmp;
  int n_bad;
  int cyc;

  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] got_q[$];
  int            got_cyc[$];

  vec_sub_pipe #(.W(W), .N(N), .CNT_W(16)) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .borrow(borrow), .out_count(out_count)
  );

  vec_sub_pipe #(.W(W), .N(N), .CNT_W(4)) dut4 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready4),
    .y(y), .b(b),
    .out_valid(out_valid4), .out_ready(out_ready),
    .a(a4), .borrow(borrow4), .out_count(out_count4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [RW-1:0] model(
    input logic [N-1:0][W-1:0] yy,
    input logic [N-1:0][W-1:0] bb
  );
    logic [N-1:0][W-1:0] d;
    logic [N-1:0]        br;
    for (int i = 0; i < N; i++) begin
      d[i]  = yy[i] - bb[i];
      br[i] = (yy[i] < bb[i]);
    end
    return {br, d};
  endfunction

  // Records transfers only; comparisons live in the test tasks.
  task automatic step(output bit in_fire);
    @(negedge clock);
    in_fire = !reset && in_valid && in_ready;
    if (!reset && out_valid && out_ready) begin
      got_q.push_back({borrow, a});
      got_cyc.push_back(cyc);
    end
    if (in_fire) exp_q.push_back(model(y, b));
    @(posedge clock);
    cyc++;
    #1;
  endtask

  task automatic apply_reset();
    bit f;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y = '0;
    b = '0;
    step(f);
    step(f);
    reset = 1'b0;
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    bit f;
    reset = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    y = 32'h11223344;
    b = 32'h01010101;
    step(f);
    step(f);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready got %b want 1", in_ready);
    end
    reset = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a, borrow, out_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_state got v=%b a=%h br=%b c=%0d want 0",
               out_valid, a, borrow, out_count);
    end
    step(f);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_after got rdy=%b v=%b want 1/0",
               in_ready, out_valid);
    end
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_basic();
    bit f;
    logic [RW-1:0] r;
    apply_reset();
    in_valid = 1'b1;
    y = {8'd10, 8'd20, 8'd30, 8'd40};
    b = {8'd1, 8'd2, 8'd3, 8'd4};
    step(f);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_early got v=%b want 0", out_valid);
    end
    step(f);
    n_cmp++;
    if (out_valid !== 1'b1 ||
        {borrow, a} !== {4'b0, 8'd9, 8'd18, 8'd27, 8'd36}) begin
      n_bad++;
      $display("FAIL basic_value got v=%b a=%h br=%b want 1 09121b24 0",
               out_valid, a, borrow);
    end
    step(f);
    step(f);
    n_cmp++;
    if (got_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++;
      $display("FAIL basic_count got %0d want 1", got_q.size());
    end else begin
      r = got_q.pop_front();
      if (r !== exp_q.pop_front()) begin
        n_bad++;
        $display("FAIL basic_sb got %h", r);
      end
    end
  endtask

  task automatic test_wrap();
    bit f;
    logic [RW-1:0] r;
    apply_reset();
    in_valid = 1'b1;
    y = {8'h00, 8'h80, 8'hFF, 8'h03};
    b = {8'h01, 8'h7F, 8'hFF, 8'h05};
    step(f);
    in_valid = 1'b0;
    repeat (3) step(f);
    n_cmp++;
    if (got_q.size() != 1) begin
      n_bad++;
      $display("FAIL wrap_count got %0d want 1", got_q.size());
    end else begin
      r = got_q.pop_front();
      if (r !== {4'b1001, 8'hFF, 8'h01, 8'h00, 8'hFE}) begin
        n_bad++;
        $display("FAIL wrap_value got %h want 9ff0100fe", r);
      end
    end
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    bit f;
    logic [RW-1:0] r;
    logic [RW-1:0] e;
    apply_reset();
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      y = $urandom();
      b = $urandom();
      step(f);
      n_cmp++;
      if (!f) begin
        n_bad++;
        $display("FAIL stream_accept vec %0d got 0 want 1", k);
      end
    end
    in_valid = 1'b0;
    repeat (3) step(f);
    n_cmp++;
    if (got_q.size() != 16 || out_count !== 16'd16) begin
      n_bad++;
      $display("FAIL stream_count got %0d/%0d want 16",
               got_q.size(), out_count);
    end
    for (int k = 1; k < got_cyc.size(); k++) begin
      n_cmp++;
      if (got_cyc[k] != got_cyc[k-1] + 1) begin
        n_bad++;
        $display("FAIL stream_gap at %0d got %0d want %0d",
                 k, got_cyc[k], got_cyc[k-1] + 1);
      end
    end
    while (got_q.size() > 0) begin
      r = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL stream_data got %h want %h", r, e);
      end
    end
  endtask

  task automatic test_stall();
    bit f;
    int acc;
    logic [RW-1:0] snap;
    logic [RW-1:0] r;
    logic [RW-1:0] e;
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    acc = 0;
    y = $urandom();
    b = $urandom();
    for (int k = 0; k < 5; k++) begin
      step(f);
      if (f) begin
        acc++;
        y = $urandom();
        b = $urandom();
      end
      if (k == 1) snap = {borrow, a};
      if (k >= 2) begin
        n_cmp++;
        if (out_valid !== 1'b1 || {borrow, a} !== snap) begin
          n_bad++;
          $display("FAIL stall_hold got v=%b %h want 1 %h",
                   out_valid, {borrow, a}, snap);
        end
      end
    end
    n_cmp++;
    if (acc != 2 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_ready got acc=%0d rdy=%b want 2/0",
               acc, in_ready);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 50 && acc < 6; k++) begin
      step(f);
      if (f) begin
        acc++;
        y = $urandom();
        b = $urandom();
      end
    end
    in_valid = 1'b0;
    repeat (4) step(f);
    n_cmp++;
    if (got_q.size() != 6) begin
      n_bad++;
      $display("FAIL stall_count got %0d want 6", got_q.size());
    end
    while (got_q.size() > 0) begin
      r = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL stall_data got %h want %h", r, e);
      end
    end
  endtask

  task automatic test_random();
    bit f;
    int acc;
    int cycles;
    logic [RW-1:0] r;
    logic [RW-1:0] e;
    int bad0;
    apply_reset();
    acc = 0;
    cycles = 0;
    bad0 = n_bad;
    y = $urandom();
    b = $urandom();
    in_valid = ($urandom_range(9) < 7);
    out_ready = ($urandom_range(9) < 7);
    while (acc < 1000 && cycles < 20000) begin
      step(f);
      cycles++;
      if (f) begin
        acc++;
        y = $urandom();
        b = $urandom();
      end
      in_valid = (acc < 1000) && ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      while (got_q.size() > 0) begin
        r = got_q.pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        n_cmp++;
        if (r !== e && n_bad - bad0 < 10) begin
          n_bad++;
          $display("FAIL random_data got %h want %h", r, e);
        end else if (r !== e) begin
          n_bad++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step(f);
    while (got_q.size() > 0) begin
      r = got_q.pop_front();
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
      n_cmp++;
      if (r !== e) begin
        n_bad++;
        $display("FAIL random_tail got %h want %h", r, e);
      end
    end
    n_cmp++;
    if (acc != 1000 || exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL random_budget got acc=%0d left=%0d want 1000/0",
               acc, exp_q.size());
    end
    n_cmp++;
    if (out_count !== 16'd1000 || out_count4 !== 4'd8) begin
      n_bad++;
      $display("FAIL random_cnt got %0d/%0d want 1000/8",
               out_count, out_count4);
    end
  endtask

  task automatic test_reset_mid();
    bit f;
    apply_reset();
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      y = $urandom();
      b = $urandom() | 32'h01010101;
      step(f);
    end
    n_cmp++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_full got v=%b rdy=%b want 1/0",
               out_valid, in_ready);
    end
    reset = 1'b1;
    step(f);
    reset = 1'b0;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, a, borrow, out_count, in_ready}
        !== {1'b0, {(N*W){1'b0}}, {N{1'b0}}, 16'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL mid_reset got v=%b a=%h br=%b c=%0d rdy=%b",
               out_valid, a, borrow, out_count, in_ready);
    end
    exp_q.delete();
    got_q.delete();
    out_ready = 1'b1;
    repeat (4) step(f);
    n_cmp++;
    if (got_q.size() != 0) begin
      n_bad++;
      $display("FAIL mid_ghost got %0d want 0", got_q.size());
    end
    in_valid = 1'b1;
    for (int k = 0; k < 17; k++) begin
      y = $urandom();
      b = $urandom();
      step(f);
    end
    in_valid = 1'b0;
    repeat (3) step(f);
    n_cmp++;
    if (out_count4 !== 4'd1 || out_count !== 16'd17) begin
      n_bad++;
      $display("FAIL cnt_wrap got %0d/%0d want 1/17",
               out_count4, out_count);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    cyc = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    y = '0;
    b = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
